key_switch_conditioner: RTL and testbench

//  Front-end conditioner for board push-buttons and slide switches ahead of the NIOS SoC PIOs.

---
 rtl/key_cond_pkg.sv | 13 +
 rtl/debounce_cell.sv | 74 +++++++
 rtl/key_switch_conditioner.sv | 57 +++++
 tb/tb_key_switch_conditioner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the key/switch conditioner.
// Debounce FSM state and default settle time.
package key_cond_pkg;

  typedef enum logic {
    DB_STABLE,
    DB_SETTLING
  } db_state_t;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchronizer plus settle-count debouncer for one word.
// A new value is accepted only after it holds for DEBOUNCE_CYCLES.
module debounce_cell
  import key_cond_pkg::*;
#(
  parameter int               WIDTH           = 1,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable_val,
  output logic             changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] cnt;
  db_state_t        state;

  // Bring the asynchronous pins into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Settle FSM: restart on any movement, accept after a full quiet window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DB_STABLE;
      stable_val <= RESET_VAL;
      candidate  <= RESET_VAL;
      cnt        <= '0;
      changed    <= 1'b0;
    end else begin
      changed <= 1'b0;
      unique case (state)
        DB_STABLE: begin
          if (sync2 != stable_val) begin
            state     <= DB_SETTLING;
            candidate <= sync2;
            cnt       <= '0;
          end
        end
        DB_SETTLING: begin
          if (sync2 == stable_val) begin
            state <= DB_STABLE;
          end else if (sync2 != candidate) begin
            candidate <= sync2;
            cnt       <= '0;
          end else if (cnt == CNT_LAST) begin
            stable_val <= candidate;
            changed    <= 1'b1;
            state      <= DB_STABLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/key_switch_conditioner.sv
// Push-button and slide-switch front end for the SoC PIOs.
// Per-key debounce with press/release pulses; SW debounced as one word.
module key_switch_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int SW_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] KEY_N,
  input  logic [SW_WIDTH-1:0] SW,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [SW_WIDTH-1:0] sw_stable,
  output logic                sw_changed
);

  logic [NUM_KEYS-1:0] key_stable_n;
  logic [NUM_KEYS-1:0] key_chg;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_cell #(
      .WIDTH          (1),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b1)
    ) u_key (
      .clk       (Clk),
      .rst       (Reset),
      .din       (KEY_N[i]),
      .stable_val(key_stable_n[i]),
      .changed   (key_chg[i])
    );
  end

  debounce_cell #(
    .WIDTH          (SW_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      ({SW_WIDTH{1'b0}})
  ) u_sw (
    .clk       (Clk),
    .rst       (Reset),
    .din       (SW),
    .stable_val(sw_stable),
    .changed   (sw_changed)
  );

  // Keys are active-low; pulses qualify the registered change flag.
  always_comb begin
    key_level   = ~key_stable_n;
    key_press   = key_chg & ~key_stable_n;
    key_release = key_chg & key_stable_n;
  end

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Directed bench for key_switch_conditioner with a 4-cycle settle window.
// Outputs are sampled on the falling edge; inputs also change there.
module tb_key_switch_conditioner;

  logic       Clk;
  logic       Reset;
  logic [1:0] KEY_N;
  logic [7:0] SW;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [7:0] sw_stable;
  logic       sw_changed;

  int checks;
  int errors;

  key_switch_conditioner #(
    .NUM_KEYS       (2),
    .SW_WIDTH       (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .KEY_N      (KEY_N),
    .SW         (SW),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .sw_stable  (sw_stable),
    .sw_changed (sw_changed)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Packed view: {level, press, release, sw_stable, sw_changed}
  logic [14:0] obs;
  assign obs = {key_level, key_press, key_release,
                sw_stable, sw_changed};

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    Reset = 1'b1;
    KEY_N = 2'b11;
    SW    = 8'h00;
    for (int i = 0; i < 3; i++) cyc();
    exp = '0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_hold got %h exp %h", obs, exp);
    end
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %h exp %h",
                 i, obs, exp);
      end
    end
  endtask

  task automatic test_press_release();
    logic [14:0] exp;
    KEY_N[1] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      exp = {(i >= 7) ? 2'b10 : 2'b00,
             (i == 7) ? 2'b10 : 2'b00,
             2'b00, 8'h00, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL press1 cyc %0d got %h exp %h",
                 i, obs, exp);
      end
    end
    KEY_N[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp = {(i >= 7) ? 2'b00 : 2'b10,
             2'b00,
             (i == 7) ? 2'b10 : 2'b00,
             8'h00, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL release1 cyc %0d got %h exp %h",
                 i, obs, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [14:0] exp;
    logic [7:0]  pat;
    pat = 8'b1000_1000;
    for (int k = 0; k < 24; k++) begin
      KEY_N[0] = (k < 8) ? pat[k] : 1'b0;
      cyc();
      exp = {(k >= 14) ? 2'b01 : 2'b00,
             (k == 14) ? 2'b01 : 2'b00,
             2'b00, 8'h00, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bounce0 k %0d got %h exp %h",
                 k, obs, exp);
      end
    end
    KEY_N[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      exp = {(i >= 7) ? 2'b00 : 2'b01,
             2'b00,
             (i == 7) ? 2'b01 : 2'b00,
             8'h00, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL release0 cyc %0d got %h exp %h",
                 i, obs, exp);
      end
    end
  endtask

  task automatic test_switch();
    logic [14:0] exp;
    SW = 8'hA5;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp = {6'b0,
             (i >= 7) ? 8'hA5 : 8'h00,
             (i == 7) ? 1'b1 : 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL sw_a5 cyc %0d got %h exp %h",
                 i, obs, exp);
      end
    end
    SW = 8'hA4;
    cyc();
    cyc();
    SW = 8'hA5;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp = {6'b0, 8'hA5, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL sw_glitch cyc %0d got %h exp %h",
                 i, obs, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [14:0] exp;
    KEY_N = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp = {(i >= 7) ? 2'b11 : 2'b00,
             (i == 7) ? 2'b11 : 2'b00,
             2'b00, 8'hA5, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL both_press cyc %0d got %h exp %h",
                 i, obs, exp);
      end
    end
    KEY_N = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp = {(i >= 7) ? 2'b00 : 2'b11,
             2'b00,
             (i == 7) ? 2'b11 : 2'b00,
             8'hA5, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL both_release cyc %0d got %h exp %h",
                 i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_settle();
    logic [14:0] exp;
    KEY_N[1] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      exp = {6'b0, 8'hA5, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL pre_reset cyc %0d got %h exp %h",
                 i, obs, exp);
      end
    end
    Reset = 1'b1;
    cyc();
    exp = '0;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL mid_reset got %h exp %h", obs, exp);
    end
    Reset = 1'b0;
    SW = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp = {(i >= 7) ? 2'b10 : 2'b00,
             (i == 7) ? 2'b10 : 2'b00,
             2'b00, 8'h00, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL post_reset cyc %0d got %h exp %h",
                 i, obs, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    KEY_N  = 2'b11;
    SW     = 8'h00;
    test_reset();
    test_press_release();
    test_bounce();
    test_switch();
    test_simultaneous();
    test_reset_mid_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
